// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: branch funct3 encodings, 2-bit predictor
// counter states and the BTB entry layout.
package rv_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Tag holds the PC shifted right past the index bits, zero-extended.
  typedef struct packed {
    logic               valid;
    logic [RV_XLEN-1:0] tag;
    logic [RV_XLEN-1:0] target;
    logic [1:0]         ctr;
  } btb_entry_t;

  function automatic logic f3IsLegal(input logic [2:0] f3);
    return (f3[2:1] != 2'b01);
  endfunction

  function automatic logic [1:0] ctrUpdate(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end else begin
      return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    end
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Pipeline-facing bus of the branch resolve unit: IF lookup, EX resolve,
// comparator handshake, redirect and event counters.
interface branch_resolve_unit_if #(parameter int XLEN = 32) ();

  logic [XLEN-1:0] if_PC;
  logic            if_PredTaken;
  logic [XLEN-1:0] if_PredTarget;
  logic            ex_Valid;
  logic            ex_Stall;
  logic            ex_Branch;
  logic            ex_Jump;
  logic [2:0]      ex_Funct3;
  logic [XLEN-1:0] ex_PC;
  logic [XLEN-1:0] ex_Target;
  logic            ex_PredTaken;
  logic [XLEN-1:0] ex_PredTarget;
  logic            BrEq;
  logic            BrLt;
  logic            BrUn;
  logic            Redirect;
  logic [XLEN-1:0] RedirectPC;
  logic [31:0]     BrCount;
  logic [31:0]     MispCount;

  modport master (
    output if_PC, ex_Valid, ex_Stall, ex_Branch, ex_Jump, ex_Funct3, ex_PC,
           ex_Target, ex_PredTaken, ex_PredTarget, BrEq, BrLt,
    input  if_PredTaken, if_PredTarget, BrUn, Redirect, RedirectPC, BrCount, MispCount
  );

  modport slave (
    input  if_PC, ex_Valid, ex_Stall, ex_Branch, ex_Jump, ex_Funct3, ex_PC,
           ex_Target, ex_PredTaken, ex_PredTarget, BrEq, BrLt,
    output if_PredTaken, if_PredTarget, BrUn, Redirect, RedirectPC, BrCount, MispCount
  );

endinterface

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: combinational lookup port and a synchronous
// update port that applies the hit/allocate rules to the addressed entry.
module btb_array
  import rv_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX     = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX-1:0]     rdIdx,
  output btb_entry_t         rdEntry,
  input  logic               wrEn,
  input  logic [IDX-1:0]     wrIdx,
  input  logic [RV_XLEN-1:0] wrTag,
  input  logic [RV_XLEN-1:0] wrTarget,
  input  logic               wrTaken,
  input  logic               wrJump
);

  btb_entry_t mem_r [ENTRIES];
  btb_entry_t curEntry_s;
  btb_entry_t nextEntry_s;
  logic       hit_s;
  logic       doWrite_s;

  // No bypass: the lookup always sees the contents before this cycle's update.
  assign rdEntry = mem_r[rdIdx];

  // Next contents of the entry addressed by the EX-stage update.
  always_comb begin
    curEntry_s  = mem_r[wrIdx];
    hit_s       = curEntry_s.valid && (curEntry_s.tag == wrTag);
    nextEntry_s = curEntry_s;
    doWrite_s   = 1'b0;
    if (wrEn && hit_s) begin
      doWrite_s = 1'b1;
      if (wrJump) begin
        nextEntry_s.ctr    = CTR_ST;
        nextEntry_s.target = wrTarget;
      end else begin
        nextEntry_s.ctr    = ctrUpdate(curEntry_s.ctr, wrTaken);
        nextEntry_s.target = wrTaken ? wrTarget : curEntry_s.target;
      end
    end else if (wrEn && wrTaken) begin
      doWrite_s          = 1'b1;
      nextEntry_s.valid  = 1'b1;
      nextEntry_s.tag    = wrTag;
      nextEntry_s.target = wrTarget;
      nextEntry_s.ctr    = wrJump ? CTR_ST : CTR_WT;
    end else begin
      doWrite_s = 1'b0;
    end
  end

  // Entry storage; reset invalidates every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_r[i] <= {$bits(btb_entry_t){1'b0}};
      end
    end else if (doWrite_s) begin
      mem_r[wrIdx] <= nextEntry_s;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: outcome from comparator flags, mispredict
// detection against the IF-stage BTB prediction, same-cycle redirect, counters.
module branch_resolve_unit
  import rv_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int XLEN        = 32
) (
  input logic              clk,
  input logic              rst_n,
  branch_resolve_unit_if.slave bus
);

  localparam int IDX = $clog2(BTB_ENTRIES);

  btb_entry_t         rdEntry_s;
  logic [IDX-1:0]     ifIdx_s;
  logic [IDX-1:0]     exIdx_s;
  logic [RV_XLEN-1:0] ifTag_s;
  logic [RV_XLEN-1:0] exTag_s;
  logic               ifHit_s;
  logic               f3Legal_s;
  logic               condTaken_s;
  logic               isBranch_s;
  logic               active_s;
  logic               actualTaken_s;
  logic               misp_s;
  logic [XLEN-1:0]    pcPlus4_s;
  logic [31:0]        brCount_r;
  logic [31:0]        mispCount_r;

  assign ifIdx_s = bus.if_PC[IDX+1:2];
  assign ifTag_s = RV_XLEN'(bus.if_PC >> (IDX + 2));
  assign exIdx_s = bus.ex_PC[IDX+1:2];
  assign exTag_s = RV_XLEN'(bus.ex_PC >> (IDX + 2));

  btb_array #(.ENTRIES(BTB_ENTRIES), .IDX(IDX)) u_btb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdIdx    (ifIdx_s),
    .rdEntry  (rdEntry_s),
    .wrEn     (active_s),
    .wrIdx    (exIdx_s),
    .wrTag    (exTag_s),
    .wrTarget (RV_XLEN'(bus.ex_Target)),
    .wrTaken  (actualTaken_s),
    .wrJump   (bus.ex_Jump)
  );

  assign ifHit_s           = rdEntry_s.valid && (rdEntry_s.tag == ifTag_s);
  assign bus.if_PredTaken  = ifHit_s & rdEntry_s.ctr[1];
  assign bus.if_PredTarget = ifHit_s ? XLEN'(rdEntry_s.target) : {XLEN{1'b0}};

  assign bus.BrUn = bus.ex_Funct3[1];

  // Actual outcome, mispredict detection and redirect target.
  always_comb begin
    f3Legal_s = f3IsLegal(bus.ex_Funct3);
    case (bus.ex_Funct3)
      F3_BEQ:  condTaken_s = bus.BrEq;
      F3_BNE:  condTaken_s = ~bus.BrEq;
      F3_BLT:  condTaken_s = bus.BrLt;
      F3_BLTU: condTaken_s = bus.BrLt;
      F3_BGE:  condTaken_s = ~bus.BrLt;
      F3_BGEU: condTaken_s = ~bus.BrLt;
      default: condTaken_s = 1'b0;
    endcase
    isBranch_s    = bus.ex_Branch & ~bus.ex_Jump & f3Legal_s;
    active_s      = bus.ex_Valid & ~bus.ex_Stall & (bus.ex_Jump | isBranch_s);
    actualTaken_s = bus.ex_Jump | (isBranch_s & condTaken_s);
    misp_s        = active_s & ((actualTaken_s != bus.ex_PredTaken) |
                                (actualTaken_s & (bus.ex_Target != bus.ex_PredTarget)));
    pcPlus4_s     = bus.ex_PC + XLEN'(32'd4);
    if (misp_s && actualTaken_s) begin
      bus.RedirectPC = bus.ex_Target;
    end else begin
      bus.RedirectPC = pcPlus4_s;
    end
    bus.Redirect = misp_s;
  end

  // Resolved-branch and mispredict event counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brCount_r   <= 32'd0;
      mispCount_r <= 32'd0;
    end else begin
      brCount_r   <= brCount_r + {31'd0, active_s};
      mispCount_r <= mispCount_r + {31'd0, misp_s};
    end
  end

  assign bus.BrCount   = brCount_r;
  assign bus.MispCount = mispCount_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (16-entry BTB, index PC[5:2]).
module tb_branch_resolve_unit;
  import rv_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  branch_resolve_unit_if #(.XLEN(32)) bus ();

  branch_resolve_unit #(.BTB_ENTRIES(16), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setEx(input logic v, input logic st, input logic br, input logic jp,
                       input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt, input logic eq, input logic lt);
    bus.ex_Valid      = v;
    bus.ex_Stall      = st;
    bus.ex_Branch     = br;
    bus.ex_Jump       = jp;
    bus.ex_Funct3     = f3;
    bus.ex_PC         = pc;
    bus.ex_Target     = tgt;
    bus.ex_PredTaken  = pt;
    bus.ex_PredTarget = ptgt;
    bus.BrEq          = eq;
    bus.BrLt          = lt;
  endtask

  task automatic idle();
    setEx(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.ex_PC = 32'h20;
    bus.if_PC = 32'h100;
    #2;
    checks++; if (bus.if_PredTaken !== 1'b0) $display("FAIL reset_predtaken: got %b want 0", bus.if_PredTaken); else passed++;
    checks++; if (bus.if_PredTarget !== 32'h0) $display("FAIL reset_predtarget: got %h want 0", bus.if_PredTarget); else passed++;
    checks++; if (bus.BrCount !== 32'd0) $display("FAIL reset_brcount: got %0d want 0", bus.BrCount); else passed++;
    checks++; if (bus.MispCount !== 32'd0) $display("FAIL reset_mispcount: got %0d want 0", bus.MispCount); else passed++;
    checks++; if (bus.Redirect !== 1'b0) $display("FAIL reset_redirect: got %b want 0", bus.Redirect); else passed++;
    checks++; if (bus.RedirectPC !== 32'h24) $display("FAIL reset_redirectpc: got %h want 24", bus.RedirectPC); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_beq_alloc();
    @(negedge clk);
    setEx(1'b1, 1'b0, 1'b1, 1'b0, F3_BEQ, 32'h100, 32'h140, 1'b0, 32'h0, 1'b1, 1'b0);
    bus.if_PC = 32'h100;
    #1;
    checks++; if (bus.Redirect !== 1'b1) $display("FAIL beq_redirect: got %b want 1", bus.Redirect); else passed++;
    checks++; if (bus.RedirectPC !== 32'h140) $display("FAIL beq_redirectpc: got %h want 140", bus.RedirectPC); else passed++;
    checks++; if (bus.BrUn !== 1'b0) $display("FAIL beq_brun: got %b want 0", bus.BrUn); else passed++;
    checks++; if (bus.if_PredTaken !== 1'b0) $display("FAIL beq_nobypass: got %b want 0", bus.if_PredTaken); else passed++;
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.if_PredTaken !== 1'b1) $display("FAIL alloc_predtaken: got %b want 1", bus.if_PredTaken); else passed++;
    checks++; if (bus.if_PredTarget !== 32'h140) $display("FAIL alloc_predtarget: got %h want 140", bus.if_PredTarget); else passed++;
    checks++; if (bus.MispCount !== 32'd1) $display("FAIL alloc_misp: got %0d want 1", bus.MispCount); else passed++;
    checks++; if (bus.BrCount !== 32'd1) $display("FAIL alloc_br: got %0d want 1", bus.BrCount); else passed++;
  endtask

  task automatic test_beq_not_taken();
    @(negedge clk);
    setEx(1'b1, 1'b0, 1'b1, 1'b0, F3_BEQ, 32'h100, 32'h140, 1'b1, 32'h140, 1'b0, 1'b0);
    #1;
    checks++; if (bus.Redirect !== 1'b1) $display("FAIL beqnt_redirect: got %b want 1", bus.Redirect); else passed++;
    checks++; if (bus.RedirectPC !== 32'h104) $display("FAIL beqnt_redirectpc: got %h want 104", bus.RedirectPC); else passed++;
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.if_PredTaken !== 1'b0) $display("FAIL beqnt_predtaken: got %b want 0", bus.if_PredTaken); else passed++;
    checks++; if (bus.if_PredTarget !== 32'h140) $display("FAIL beqnt_predtarget: got %h want 140", bus.if_PredTarget); else passed++;
    checks++; if (bus.MispCount !== 32'd2) $display("FAIL beqnt_misp: got %0d want 2", bus.MispCount); else passed++;
  endtask

  task automatic test_bne();
    @(negedge clk);
    setEx(1'b1, 1'b0, 1'b1, 1'b0, F3_BNE, 32'h100, 32'h180, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    checks++; if (bus.Redirect !== 1'b0) $display("FAIL bne_ok_redirect: got %b want 0", bus.Redirect); else passed++;
    checks++; if (bus.RedirectPC !== 32'h104) $display("FAIL bne_ok_redirectpc: got %h want 104", bus.RedirectPC); else passed++;
    @(negedge clk);
    setEx(1'b1, 1'b0, 1'b1, 1'b0, F3_BNE, 32'h100, 32'h180, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.RedirectPC !== 32'h180) $display("FAIL bne_tk_redirectpc: got %h want 180", bus.RedirectPC); else passed++;
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.if_PredTaken !== 1'b0) $display("FAIL bne_predtaken: got %b want 0", bus.if_PredTaken); else passed++;
    checks++; if (bus.if_PredTarget !== 32'h180) $display("FAIL bne_predtarget: got %h want 180", bus.if_PredTarget); else passed++;
    checks++; if (bus.BrCount !== 32'd4) $display("FAIL bne_br: got %0d want 4", bus.BrCount); else passed++;
    checks++; if (bus.MispCount !== 32'd3) $display("FAIL bne_misp: got %0d want 3", bus.MispCount); else passed++;
  endtask

  task automatic test_compare_ops();
    @(negedge clk);
    setEx(1'b1, 1'b0, 1'b1, 1'b0, F3_BLTU, 32'h44, 32'h80, 1'b1, 32'h80, 1'b0, 1'b1);
    #1;
    checks++; if (bus.BrUn !== 1'b1) $display("FAIL bltu_brun: got %b want 1", bus.BrUn); else passed++;
    checks++; if (bus.Redirect !== 1'b0) $display("FAIL bltu_redirect: got %b want 0", bus.Redirect); else passed++;
    checks++; if (bus.RedirectPC !== 32'h48) $display("FAIL bltu_redirectpc: got %h want 48", bus.RedirectPC); else passed++;
    @(negedge clk);
    setEx(1'b1, 1'b0, 1'b1, 1'b0, F3_BGE, 32'h48, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.BrUn !== 1'b0) $display("FAIL bge_brun: got %b want 0", bus.BrUn); else passed++;
    checks++; if (bus.Redirect !== 1'b1) $display("FAIL bge_redirect: got %b want 1", bus.Redirect); else passed++;
    checks++; if (bus.RedirectPC !== 32'h20) $display("FAIL bge_redirectpc: got %h want 20", bus.RedirectPC); else passed++;
    @(negedge clk);
    setEx(1'b0, 1'b0, 1'b1, 1'b0, F3_BGEU, 32'h50, 32'h90, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.BrUn !== 1'b1) $display("FAIL bubble_brun: got %b want 1", bus.BrUn); else passed++;
    checks++; if (bus.Redirect !== 1'b0) $display("FAIL bubble_redirect: got %b want 0", bus.Redirect); else passed++;
    checks++; if (bus.BrCount !== 32'd6) $display("FAIL cmp_br: got %0d want 6", bus.BrCount); else passed++;
    checks++; if (bus.MispCount !== 32'd4) $display("FAIL cmp_misp: got %0d want 4", bus.MispCount); else passed++;
  endtask

  task automatic test_jalr();
    @(negedge clk);
    setEx(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h200, 32'h310, 1'b1, 32'h300, 1'b0, 1'b0);
    #1;
    checks++; if (bus.Redirect !== 1'b1) $display("FAIL jalr_redirect: got %b want 1", bus.Redirect); else passed++;
    checks++; if (bus.RedirectPC !== 32'h310) $display("FAIL jalr_redirectpc: got %h want 310", bus.RedirectPC); else passed++;
    @(negedge clk);
    idle();
    bus.if_PC = 32'h200;
    #1;
    checks++; if (bus.if_PredTaken !== 1'b1) $display("FAIL jalr_predtaken: got %b want 1", bus.if_PredTaken); else passed++;
    checks++; if (bus.if_PredTarget !== 32'h310) $display("FAIL jalr_predtarget: got %h want 310", bus.if_PredTarget); else passed++;
    bus.if_PC = 32'h100;
    #1;
    checks++; if (bus.if_PredTarget !== 32'h0) $display("FAIL evicted_predtarget: got %h want 0", bus.if_PredTarget); else passed++;
    bus.if_PC = 32'h44;
    #1;
    checks++; if (bus.if_PredTarget !== 32'h80) $display("FAIL idx1_predtarget: got %h want 80", bus.if_PredTarget); else passed++;
    checks++; if (bus.MispCount !== 32'd5) $display("FAIL jalr_misp: got %0d want 5", bus.MispCount); else passed++;
  endtask

  task automatic test_stall_illegal();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      setEx(1'b1, 1'b1, 1'b1, 1'b0, F3_BLT, 32'hC, 32'h60, 1'b0, 32'h0, 1'b0, 1'b1);
      #1;
      checks++; if (bus.Redirect !== 1'b0) $display("FAIL stall_redirect[%0d]: got %b want 0", i, bus.Redirect); else passed++;
      checks++; if (bus.BrCount !== 32'd7) $display("FAIL stall_br[%0d]: got %0d want 7", i, bus.BrCount); else passed++;
    end
    @(negedge clk);
    bus.ex_Stall = 1'b0;
    #1;
    checks++; if (bus.Redirect !== 1'b1) $display("FAIL release_redirect: got %b want 1", bus.Redirect); else passed++;
    checks++; if (bus.RedirectPC !== 32'h60) $display("FAIL release_redirectpc: got %h want 60", bus.RedirectPC); else passed++;
    @(negedge clk);
    setEx(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'hC, 32'h60, 1'b1, 32'h60, 1'b1, 1'b1);
    #1;
    checks++; if (bus.BrCount !== 32'd8) $display("FAIL release_br: got %0d want 8", bus.BrCount); else passed++;
    checks++; if (bus.MispCount !== 32'd6) $display("FAIL release_misp: got %0d want 6", bus.MispCount); else passed++;
    checks++; if (bus.Redirect !== 1'b0) $display("FAIL illegal_redirect: got %b want 0", bus.Redirect); else passed++;
    checks++; if (bus.RedirectPC !== 32'h10) $display("FAIL illegal_redirectpc: got %h want 10", bus.RedirectPC); else passed++;
    @(negedge clk);
    idle();
    bus.if_PC = 32'hC;
    #1;
    checks++; if (bus.BrCount !== 32'd8) $display("FAIL illegal_br: got %0d want 8", bus.BrCount); else passed++;
    checks++; if (bus.MispCount !== 32'd6) $display("FAIL illegal_misp: got %0d want 6", bus.MispCount); else passed++;
    checks++; if (bus.if_PredTarget !== 32'h60) $display("FAIL stall_predtarget: got %h want 60", bus.if_PredTarget); else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    setEx(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h44, 32'h80, 1'b1, 32'h80, 1'b0, 1'b0);
    bus.if_PC = 32'h44;
    #1;
    checks++; if (bus.Redirect !== 1'b0) $display("FAIL b2b_jal_redirect: got %b want 0", bus.Redirect); else passed++;
    @(negedge clk);
    setEx(1'b1, 1'b0, 1'b1, 1'b0, F3_BLTU, 32'h44, 32'h80, 1'b1, 32'h80, 1'b0, 1'b0);
    #1;
    checks++; if (bus.Redirect !== 1'b1) $display("FAIL b2b_bltu_redirect: got %b want 1", bus.Redirect); else passed++;
    checks++; if (bus.RedirectPC !== 32'h48) $display("FAIL b2b_bltu_redirectpc: got %h want 48", bus.RedirectPC); else passed++;
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.if_PredTaken !== 1'b1) $display("FAIL b2b_predtaken: got %b want 1", bus.if_PredTaken); else passed++;
    checks++; if (bus.BrCount !== 32'd10) $display("FAIL b2b_br: got %0d want 10", bus.BrCount); else passed++;
    checks++; if (bus.MispCount !== 32'd7) $display("FAIL b2b_misp: got %0d want 7", bus.MispCount); else passed++;
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    setEx(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h44, 32'h88, 1'b0, 32'h0, 1'b0, 1'b0);
    bus.if_PC = 32'h44;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.BrCount !== 32'd0) $display("FAIL midrst_br: got %0d want 0", bus.BrCount); else passed++;
    checks++; if (bus.MispCount !== 32'd0) $display("FAIL midrst_misp: got %0d want 0", bus.MispCount); else passed++;
    checks++; if (bus.if_PredTaken !== 1'b0) $display("FAIL midrst_predtaken: got %b want 0", bus.if_PredTaken); else passed++;
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.if_PredTarget !== 32'h0) $display("FAIL midrst_lost_update: got %h want 0", bus.if_PredTarget); else passed++;
    checks++; if (bus.BrCount !== 32'd0) $display("FAIL midrst_br_after: got %0d want 0", bus.BrCount); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_beq_alloc();
    test_beq_not_taken();
    test_bne();
    test_compare_ops();
    test_jalr();
    test_stall_illegal();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
